// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, word-length codes and defaults
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam logic [1:0] WLS_5 = 2'd0, WLS_6 = 2'd1, WLS_7 = 2'd2, WLS_8 = 2'd3;
  localparam int OSR_DEFAULT = 16;
  function automatic logic [7:0] wls_mask(input logic [1:0] wls);
    return 8'hff >> (WLS_8 - wls);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with runtime depth limit, flush and overflow pulse
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW:0]      lim,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             empty,
  output logic             empty_nxt,
  output logic             ovf
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] level_nxt;
  logic pop, push;
  assign pop = re && !empty;
  // a pop in the same cycle frees the slot, so a write to a full FIFO is still taken
  assign push = we && !clr && (level < lim || pop);
  assign level_nxt = clr ? '0 : level + (AW+1)'(push) - (AW+1)'(pop);
  assign empty_nxt = level_nxt == '0;
  assign rdata = mem[rp];
  always_ff @(posedge CLK)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      empty <= 1'b1;
      ovf <= 1'b0;
    end else begin
      wp <= clr ? '0 : wp + AW'(push);
      rp <= clr ? '0 : rp + AW'(pop);
      level <= level_nxt;
      empty <= empty_nxt;
      ovf <= we && !clr && !push;
    end
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter with FIFO, parity, break and CTS flow control
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OSR = OSR_DEFAULT,
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int TW = $clog2(2 * OSR)
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          BAUD_TICK,
  input  logic          THR_WE,
  input  logic [7:0]    THR_WDATA,
  input  logic          FIFO_EN,
  input  logic          FIFO_CLR,
  input  logic [1:0]    WLS,
  input  logic          STB,
  input  logic          PEN,
  input  logic          EPS,
  input  logic          SP,
  input  logic          BC,
  input  logic          AFE,
  input  logic          CTS,
  output logic          TXD,
  output logic          THRE,
  output logic          TEMT,
  output logic [LW-1:0] TX_LEVEL,
  output logic          TX_OVF
);
  uart_state_t state;
  logic [TW-1:0] tick, last;
  logic [2:0] bit_cnt;
  logic [7:0] sh, head, din;
  logic [1:0] wls_q;
  logic stb_q, pen_q, par_q;
  logic empty_nxt, bit_end, pop, idle_nxt;
  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .clr      (FIFO_CLR),
    .we       (THR_WE),
    .wdata    (THR_WDATA),
    .re       (pop),
    .lim      (FIFO_EN ? LW'(FIFO_DEPTH) : LW'(1)),
    .rdata    (head),
    .level    (TX_LEVEL),
    .empty    (THRE),
    .empty_nxt(empty_nxt),
    .ovf      (TX_OVF)
  );
  assign last = state != STOP || !stb_q ? TW'(OSR - 1) :
                wls_q == WLS_5 ? TW'(3 * OSR / 2 - 1) : TW'(2 * OSR - 1);
  assign bit_end = state != IDLE && BAUD_TICK && tick == last;
  // the end of a stop bit doubles as an idle decision point, giving gapless back-to-back frames
  assign pop = (state == IDLE || (state == STOP && bit_end)) && !THRE && (!AFE || CTS);
  assign idle_nxt = !pop && (state == IDLE || (state == STOP && bit_end));
  assign din = head & wls_mask(WLS);
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      state <= IDLE;
      tick <= '0;
      bit_cnt <= '0;
      sh <= '0;
      wls_q <= '0;
      stb_q <= 1'b0;
      pen_q <= 1'b0;
      par_q <= 1'b0;
      TXD <= 1'b1;
      TEMT <= 1'b1;
    end else begin
      TXD <= !BC && (state == START ? 1'b0 : state == DATA ? sh[0] : state == PARITY ? par_q : 1'b1);
      TEMT <= idle_nxt && empty_nxt;
      tick <= state == IDLE || bit_end ? '0 : tick + TW'(BAUD_TICK);
      if (pop) begin
        state <= START;
        sh <= din;
        bit_cnt <= '0;
        wls_q <= WLS;
        stb_q <= STB;
        pen_q <= PEN;
        par_q <= SP ? !EPS : ^din ^ !EPS;
      end else if (bit_end) begin
        state <= state == START ? DATA :
                 state == DATA ? (bit_cnt == {1'b0, wls_q} + 3'd4 ? (pen_q ? PARITY : STOP) : DATA) :
                 state == PARITY ? STOP : IDLE;
        sh <= state == DATA ? sh >> 1 : sh;
        bit_cnt <= state == DATA ? bit_cnt + 3'd1 : bit_cnt;
      end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed self-checking bench for uart_tx_engine
module tb_uart_tx_engine;
  logic CLK = 1'b0, RESETn = 1'b0, BAUD_TICK = 1'b0, THR_WE = 1'b0;
  logic FIFO_EN = 1'b1, FIFO_CLR = 1'b0;
  logic [7:0] THR_WDATA = 8'h00;
  logic [1:0] WLS = 2'd3;
  logic STB = 1'b0, PEN = 1'b0, EPS = 1'b0, SP = 1'b0, BC = 1'b0, AFE = 1'b0, CTS = 1'b0;
  logic TXD, THRE, TEMT, TX_OVF;
  logic [4:0] TX_LEVEL;
  int checks = 0, failures = 0, tdiv = 0, ovf_cnt = 0;
  logic q[$];

  always #5 CLK = ~CLK;

  uart_tx_engine dut (
    .CLK(CLK), .RESETn(RESETn), .BAUD_TICK(BAUD_TICK), .THR_WE(THR_WE), .THR_WDATA(THR_WDATA),
    .FIFO_EN(FIFO_EN), .FIFO_CLR(FIFO_CLR), .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP),
    .BC(BC), .AFE(AFE), .CTS(CTS), .TXD(TXD), .THRE(THRE), .TEMT(TEMT), .TX_LEVEL(TX_LEVEL),
    .TX_OVF(TX_OVF)
  );

  // one baud tick every 3 clocks; TXD is recorded once per tick, so 16 samples make one bit
  always @(negedge CLK) begin
    if (BAUD_TICK) q.push_back(TXD);
    if (TX_OVF) ovf_cnt++;
    tdiv = tdiv == 2 ? 0 : tdiv + 1;
    BAUD_TICK = tdiv == 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic write(input logic [7:0] d);
    THR_WDATA = d;
    THR_WE = 1'b1;
    @(negedge CLK);
    THR_WE = 1'b0;
  endtask

  task automatic wait_temt(input string tag);
    int n = 0;
    while (!TEMT && n < 4000) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_temt"}, 32'(TEMT), 1);
    @(negedge CLK);
  endtask

  task automatic wait_q(input int len, input string tag);
    int n = 0;
    while (q.size() < len && n < 10000) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_wait"}, 32'(q.size() >= len), 1);
  endtask

  function automatic logic smp(input int i);
    return (i >= 0 && i < q.size()) ? q[i] : 1'bx;
  endfunction

  function automatic int find_start(input int from);
    for (int i = from; i < q.size(); i++) if (q[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int zeros(input int from);
    int z = 0;
    for (int i = (from < 0 ? 0 : from); i < q.size(); i++) if (q[i] !== 1'b1) z++;
    return z;
  endfunction

  // seq holds start, data and parity bits in transmit order (bit 0 first); stop_t is the stop length in ticks
  task automatic check_frame(input string tag, input int s, input int nb, input logic [15:0] seq, input int stop_t);
    logic [15:0] mid = '0;
    int err = 0;
    for (int i = 0; i < nb; i++) begin
      mid[i] = smp(s + 16 * i + 8);
      if (smp(s + 16 * i) !== seq[i] || smp(s + 16 * i + 15) !== seq[i]) err++;
    end
    for (int i = 0; i < stop_t; i++) if (smp(s + 16 * nb + i) !== 1'b1) err++;
    chk({tag, "_bits"}, 32'(mid), 32'(seq));
    chk({tag, "_len"}, err, 0);
  endtask

  initial begin
    int s, s2;
    cyc(3);
    chk("rst_txd", 32'(TXD), 1);
    chk("rst_thre", 32'(THRE), 1);
    chk("rst_temt", 32'(TEMT), 1);
    chk("rst_level", 32'(TX_LEVEL), 0);
    chk("rst_ovf", 32'(TX_OVF), 0);
    RESETn = 1'b1;
    cyc(1);

    q.delete();
    write(8'h55);
    chk("t1_temt_busy", 32'(TEMT), 0);
    wait_temt("t1");
    s = find_start(0);
    chk("t1_start", 32'(s >= 0), 1);
    check_frame("t1", s, 9, 16'h00AA, 16);
    chk("t1_temt_at_stop_end", q.size() - s, 160);

    WLS = 2'd2; PEN = 1'b1; EPS = 1'b1;
    q.delete();
    write(8'h07);
    wait_temt("t2a");
    s = find_start(0);
    check_frame("t2a", s, 9, 16'h010E, 16);
    SP = 1'b1;
    q.delete();
    write(8'h87);
    cyc(3);
    WLS = 2'd3; PEN = 1'b0; SP = 1'b0; EPS = 1'b0;
    wait_temt("t2b");
    s = find_start(0);
    check_frame("t2b", s, 9, 16'h000E, 16);

    AFE = 1'b1; CTS = 1'b0; ovf_cnt = 0;
    q.delete();
    for (int i = 0; i < 17; i++) write(8'hA0 + 8'(i));
    cyc(1);
    chk("t3_level", 32'(TX_LEVEL), 16);
    chk("t3_ovf", ovf_cnt, 1);
    chk("t3_thre", 32'(THRE), 0);
    chk("t3_temt", 32'(TEMT), 0);
    chk("t3_txd_idle", zeros(0), 0);
    q.delete();
    CTS = 1'b1; THR_WDATA = 8'hC3; THR_WE = 1'b1;
    @(negedge CLK);
    THR_WE = 1'b0; CTS = 1'b0;
    cyc(1);
    chk("t3_full_wr_pop_level", 32'(TX_LEVEL), 16);
    chk("t3_full_wr_pop_ovf", ovf_cnt, 1);
    cyc(20);
    FIFO_CLR = 1'b1; THR_WDATA = 8'h11; THR_WE = 1'b1;
    @(negedge CLK);
    FIFO_CLR = 1'b0; THR_WE = 1'b0;
    chk("t3_clr_level", 32'(TX_LEVEL), 0);
    chk("t3_clr_thre", 32'(THRE), 1);
    chk("t3_clr_temt", 32'(TEMT), 0);
    chk("t3_clr_ovf", 32'(TX_OVF), 0);
    wait_temt("t3");
    s = find_start(0);
    check_frame("t3", s, 9, 16'h0140, 16);
    chk("t3_temt_at_stop_end", q.size() - s, 160);

    FIFO_EN = 1'b0; ovf_cnt = 0;
    write(8'h01);
    write(8'h02);
    cyc(1);
    chk("t4_level", 32'(TX_LEVEL), 1);
    chk("t4_ovf", ovf_cnt, 1);
    FIFO_CLR = 1'b1;
    cyc(1);
    FIFO_CLR = 1'b0;
    chk("t4_clr_level", 32'(TX_LEVEL), 0);
    FIFO_EN = 1'b1;

    write(8'h0F);
    write(8'hF0);
    write(8'h33);
    cyc(1);
    chk("t5_level_q", 32'(TX_LEVEL), 3);
    q.delete();
    CTS = 1'b1;
    wait_q(240, "t5_mid2");
    CTS = 1'b0;
    wait_q(560, "t5_hold");
    chk("t5_level", 32'(TX_LEVEL), 1);
    chk("t5_temt", 32'(TEMT), 0);
    s = find_start(0);
    check_frame("t5f1", s, 9, 16'h001E, 16);
    chk("t5_gap12", 32'(smp(s + 160)), 0);
    check_frame("t5f2", s + 160, 9, 16'h01E0, 16);
    chk("t5_hold_idle", zeros(s + 320), 0);
    CTS = 1'b1;
    wait_temt("t5");
    s2 = find_start(s + 320);
    check_frame("t5f3", s2, 9, 16'h0066, 16);
    chk("t5_temt_at_stop_end", q.size() - s2, 160);

    AFE = 1'b0; WLS = 2'd0; STB = 1'b1;
    q.delete();
    write(8'h15);
    write(8'h0A);
    wait_temt("t6");
    s = find_start(0);
    check_frame("t6f1", s, 6, 16'h002A, 24);
    chk("t6_gap", 32'(smp(s + 120)), 0);
    check_frame("t6f2", s + 120, 6, 16'h0014, 24);
    chk("t6_temt_at_stop_end", q.size() - s, 240);
    q.delete();
    write(8'h1F);
    wait_q(48, "t6_bc");
    chk("t6_bc_pre", 32'(TXD), 1);
    BC = 1'b1;
    @(negedge CLK);
    chk("t6_bc_on", 32'(TXD), 0);
    cyc(10);
    chk("t6_bc_hold", 32'(TXD), 0);
    BC = 1'b0;
    @(negedge CLK);
    chk("t6_bc_off", 32'(TXD), 1);
    wait_temt("t6bc");
    s = find_start(0);
    chk("t6_bc_temt_at_stop_end", q.size() - s, 120);

    WLS = 2'd3; STB = 1'b0;
    q.delete();
    for (int i = 0; i < 5; i++) write(8'h10 + 8'(i));
    wait_q(30, "t7");
    chk("t7_pre_txd", 32'(TXD), 0);
    #2 RESETn = 1'b0;
    #1;
    chk("t7_txd", 32'(TXD), 1);
    chk("t7_level", 32'(TX_LEVEL), 0);
    chk("t7_thre", 32'(THRE), 1);
    chk("t7_temt", 32'(TEMT), 1);
    chk("t7_ovf", 32'(TX_OVF), 0);
    @(negedge CLK);
    RESETn = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries (power of 2).
REQ-002 SHALL have parameter OSR, default 16, meaning BAUD_TICK pulses per bit period.
REQ-003 SHALL have port CLK  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port RESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port BAUD_TICK  input  1  one-CLK pulse from baud generator at OSR x baud rate.
REQ-006 SHALL have port THR_WE  input  1  write strobe, one byte pushed per high cycle.
REQ-007 SHALL have port THR_WDATA  input  8  byte to transmit (upper bits ignored when WLS < 3).
REQ-008 SHALL have port FIFO_EN  input  1  1 = FIFO depth FIFO_DEPTH; 0 = single holding register (depth 1).
REQ-009 SHALL have port FIFO_CLR  input  1  one-cycle pulse, flushes FIFO.
REQ-010 SHALL have port WLS  input  2  word length: 0..3 -> 5..8 data bits.
REQ-011 SHALL have port STB  input  1  stop bits: 0 = 1; 1 = 2 (1.5 when WLS = 0).
REQ-012 SHALL have ports PEN, EPS, SP  input  1 each  parity enable, even parity select, stick parity.
REQ-013 SHALL have port BC  input  1  break control, forces TXD low.
REQ-014 SHALL have ports AFE, CTS  input  1 each  auto flow enable; clear-to-send, active-high.
REQ-015 SHALL have port TXD  output  1  serial output, idle high.
REQ-016 SHALL have ports THRE, TEMT  output  1 each  FIFO empty; FIFO empty and shifter idle.
REQ-017 SHALL have port TX_LEVEL  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-018 SHALL have port TX_OVF  output  1  one-cycle pulse when a write is dropped because the FIFO is full.

Function
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; each bit lasts OSR BAUD_TICKs, counted by a tick counter.
REQ-020 In IDLE, when FIFO non-empty and (AFE = 0 or CTS = 1), the engine SHALL pop the head into the shift register and enter START on the next cycle, with tick counter cleared.
REQ-021 CTS SHALL be sampled only in IDLE; deasserting CTS mid-character SHALL NOT abort the character.
REQ-022 TXD SHALL be 0 in START, data LSB-first in DATA (WLS+5 bits), the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-023 PARITY SHALL be entered only when PEN = 1; bit value = XOR of data bits, inverted when EPS = 0; with SP = 1 the value SHALL be ~EPS.
REQ-024 STOP SHALL last OSR ticks (STB = 0), 2*OSR ticks (STB = 1, WLS != 0) or 3*OSR/2 ticks (STB = 1, WLS = 0), then return to IDLE.
REQ-025 Back-to-back characters SHALL have no idle bit between them when the FIFO is non-empty at STOP end.
REQ-026 Framing controls (WLS, STB, PEN, EPS, SP) SHALL be latched at pop; changes mid-character SHALL NOT affect the current character.
REQ-027 BC = 1 SHALL force TXD = 0 combinationally-registered (one-cycle latency) while the FSM continues unaffected.
REQ-028 A write when occupancy = effective depth SHALL be dropped, pulse TX_OVF, and leave TX_LEVEL unchanged; a simultaneous write and pop when full SHALL accept the write.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; TX_LEVEL SHALL range 0..FIFO_DEPTH.
REQ-030 FIFO_CLR SHALL zero pointers and TX_LEVEL in the next cycle, have priority over a simultaneous write, and SHALL NOT abort the character in the shifter.
REQ-031 THRE, TEMT and TX_LEVEL SHALL be registered and reflect state one cycle after the causing event.

Reset
REQ-032 On RESETn low: FSM = IDLE, counters and pointers = 0, TXD = 1, THRE = 1, TEMT = 1, TX_LEVEL = 0, TX_OVF = 0.
REQ-033 Reset asserted mid-character SHALL return TXD to 1 immediately and discard FIFO contents.

Structure
REQ-034 FSM state encoding, WLS codes and OSR default SHALL live in shared package uart_pkg.
REQ-035 The FIFO SHALL be a sub-module uart_sync_fifo (parameterised depth and width), reusable by the receiver.

Verification
REQ-036 WLS = 3, PEN = 0, STB = 0, write 0x55 -> TXD: 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks, TEMT high 1 cycle after stop end.
REQ-037 WLS = 2, PEN = 1, EPS = 1, write 0x07 -> 7 data bits 1110000, parity 1; SP = 1, EPS = 1 -> parity 0.
REQ-038 FIFO_EN = 1, write 17 bytes in 17 cycles with CTS = 0, AFE = 1 -> TX_LEVEL = 16, one TX_OVF pulse, TXD stays 1.
REQ-039 With 3 bytes queued, raise CTS -> three back-to-back frames, no idle gap; drop CTS mid-frame 2 -> frame 2 completes, frame 3 waits.
REQ-040 WLS = 0, STB = 1 -> stop bit 24 ticks; BC = 1 mid-frame -> TXD = 0 next cycle, THRE/TEMT timing unchanged.
REQ-041 RESETn low during DATA with 5 bytes queued -> TXD = 1, TX_LEVEL = 0, THRE = TEMT = 1.
